// File: rtl/register_file_mp.sv
// Multi-port register file with a busy scoreboard for operand stalls.
// Two clocked write ports, NUM_READ combinational read ports, r0 hardwired to zero.
module register_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]   rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0]   rd_data,
    output logic [NUM_READ-1:0]              rd_busy,
    input  logic                             wr0_en,
    input  logic [ADDR_WIDTH-1:0]            wr0_reg,
    input  logic [DATA_WIDTH-1:0]            wr0_data,
    input  logic                             wr1_en,
    input  logic [ADDR_WIDTH-1:0]            wr1_reg,
    input  logic [DATA_WIDTH-1:0]            wr1_data,
    input  logic                             mark_en,
    input  logic [ADDR_WIDTH-1:0]            mark_reg,
    output logic                             any_busy
);

    generate
        if (ADDR_WIDTH != $clog2(NUM_REGS) || NUM_REGS < 2 || NUM_REGS > 256 ||
            NUM_READ < 1 || NUM_READ > 4) begin : g_bad_params
            $error("register_file_mp: inconsistent parameters");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   wr0_hit;
    logic [NUM_REGS-1:0]   wr1_hit;
    logic [NUM_REGS-1:0]   mark_hit;

    // One-hot decode starting at 1: r0 and indices >= NUM_REGS never hit anything.
    always_comb begin
        wr0_hit  = '0;
        wr1_hit  = '0;
        mark_hit = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            wr0_hit[i]  = wr0_en  && (int'(wr0_reg)  == i);
            wr1_hit[i]  = wr1_en  && (int'(wr1_reg)  == i);
            mark_hit[i] = mark_en && (int'(mark_reg) == i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr1_hit[i]) begin
                    regs[i] <= wr1_data;
                end else if (wr0_hit[i]) begin
                    regs[i] <= wr0_data;
                end
                // A new producer issuing wins over an older one retiring.
                if (mark_hit[i]) begin
                    busy_q[i] <= 1'b1;
                end else if (wr0_hit[i] || wr1_hit[i]) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    // Reads are gated by reset so bypassed write data cannot leak out while in reset.
    // With BYPASS, a same-cycle mark of the read register also shows as busy.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        if (!reset) begin
            for (int p = 0; p < NUM_READ; p++) begin
                for (int i = 1; i < NUM_REGS; i++) begin
                    if (int'(rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]) == i) begin
                        rd_data[p*DATA_WIDTH +: DATA_WIDTH] = regs[i];
                        rd_busy[p] = busy_q[i];
                        if (BYPASS != 0) begin
                            if (wr1_hit[i]) begin
                                rd_data[p*DATA_WIDTH +: DATA_WIDTH] = wr1_data;
                            end else if (wr0_hit[i]) begin
                                rd_data[p*DATA_WIDTH +: DATA_WIDTH] = wr0_data;
                            end
                            if (mark_hit[i]) begin
                                rd_busy[p] = 1'b1;
                            end else if (wr0_hit[i] || wr1_hit[i]) begin
                                rd_busy[p] = 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

    assign any_busy = |busy_q;

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port register file for the CPU datapath, successor to the single-port combinational register file. It provides clocked writes from two write ports and NUM_READ combinational read ports with optional same-cycle write-to-read bypass. A per-register busy scoreboard lets the decode stage stall on operands still being produced. Register 0 is hardwired to zero.

## Interface
- DATA_WIDTH, 32, register width in bits
- NUM_REGS, 32, number of registers (2..256)
- ADDR_WIDTH, 5, register index width; must equal $clog2(NUM_REGS)
- NUM_READ, 2, number of read ports (1..4)
- BYPASS, 1, 1 = a same-cycle write is visible on matching read ports; 0 = reads show stored value only
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all registers and busy bits
- rd_addr  in  NUM_READ*ADDR_WIDTH  read indices; port i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data  out  NUM_READ*DATA_WIDTH  read data; port i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
- rd_busy  out  NUM_READ  1 = the register addressed by port i has a pending producer
- wr0_en, wr1_en  in  1 each  write enables
- wr0_reg, wr1_reg  in  ADDR_WIDTH each  write indices
- wr0_data, wr1_data  in  DATA_WIDTH each  write data
- mark_en  in  1  set the busy bit of mark_reg (instruction issued with this destination)
- mark_reg  in  ADDR_WIDTH  register to mark busy
- any_busy  out  1  OR of all busy bits

## Operation
- Storage: NUM_REGS x DATA_WIDTH flops, plus a NUM_REGS-bit busy vector.
- Register 0: never written, never marked busy; reads always return 0 with busy 0.
- Out-of-range index (>= NUM_REGS): writes and marks ignored; reads return 0, busy 0.
- Write: on the rising edge, if wrX_en and wrX_reg != 0, registers[wrX_reg] <= wrX_data, and busy[wrX_reg] is cleared.
- Dual write, same register: wr1 wins; the register takes wr1_data and the busy bit is cleared once.
- Mark: on the rising edge, if mark_en and mark_reg != 0, busy[mark_reg] <= 1.
- Mark and write to the same register in the same cycle: mark wins, so busy ends at 1 and the data is written. This models a new producer issuing while an older one retires.
- Read, combinational, per port:
  - BYPASS=1 and a write is enabled to a matching nonzero rd_addr: rd_data = that write's data (wr1 over wr0). rd_busy = 0, unless mark_en targets the same register, in which case rd_busy = 1.
  - Otherwise: rd_data = registers[rd_addr], rd_busy = busy[rd_addr].
- any_busy reflects the registered busy vector only; it is not bypassed.

## Timing
- Reset asserted: all registers = 0, busy = 0, any_busy = 0, and every rd_data / rd_busy = 0 immediately, without waiting for a clock edge. Reset dominates writes and marks on the same edge.
- Reset deasserted mid-operation: the first active edge after deassertion performs normal writes and marks; no writes or marks are lost except those on edges where reset was high.
- Write-to-read latency:
  - BYPASS=1: 0 cycles.
  - BYPASS=0: value visible on the cycle after the write edge.
- Mark-to-busy latency:
  - rd_busy and any_busy assert in the cycle after the mark edge.
  - BYPASS=1 with mark and read of the same register in the same cycle: rd_busy = 1 in that cycle.
- No handshake: a write or mark is accepted on every edge where it is enabled. There is no backpressure.
- The read path is purely combinational from rd_addr and the write/mark inputs to rd_data and rd_busy. There is no flop on the read path.

## Test plan
- Reset: write 0xDEADBEEF to r5, then assert reset between clock edges -> rd_data of r5 = 0 immediately; any_busy = 0.
- Write then read, BYPASS=1 and BYPASS=0: wr0 writes 0x12345678 to r3 while port 0 reads r3 -> BYPASS=1: 0x12345678 in the same cycle; BYPASS=0: old value 0 that cycle, 0x12345678 on the next.
- Zero register: wr0 writes 0xFFFFFFFF to r0 and mark_en targets r0 -> r0 reads 0, rd_busy 0, any_busy 0.
- Write collision: wr0 writes 0x11 and wr1 writes 0x22 to r7 in the same cycle -> r7 = 0x22 afterwards; with BYPASS=1, same-cycle read of r7 = 0x22.
- Scoreboard: mark r9, then wait 2 cycles -> rd_busy = 1 and any_busy = 1. Then wr1 writes 0xAB to r9 -> next cycle busy = 0, data = 0xAB. Mark and write r9 together -> busy stays 1, data updated.
- Parameter sweep: NUM_REGS=16, ADDR_WIDTH=4, NUM_READ=3, DATA_WIDTH=64 -> write a distinct pattern to r1..r15, then read all three ports simultaneously -> each port returns its own register's value.
